// File: rtl/cache_assoc_array.sv
// rtl/cache_assoc_array.sv - set-associative write-back cache tag/data array with LRU, eviction, fill and flush
//
// Ports:
//   clk, reset_n                      rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake (accepted only in IDLE without flush)
//   req_addr, req_write, req_wdata,   16-bit byte address, write flag, write data,
//   req_wmask                         byte enables {hi, lo}
//   resp_valid, resp_hit, resp_rdata  one-cycle response; resp_hit = first lookup hit
//   wb_valid/wb_ready, wb_addr,       line write-back handshake, line-aligned address,
//   wb_data                           victim line contents
//   fill_req, fill_addr, fill_done,   line fill request and completion with line data
//   fill_data
//   flush_req, flush_done             level flush request, one-cycle completion pulse
module cache_assoc_array #(
  parameter int WAYS        = 2,
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 4,
  localparam int LINE_BITS  = 8 << OFFSET_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [15:0]          req_addr,
  input  logic                 req_write,
  input  logic [15:0]          req_wdata,
  input  logic [1:0]           req_wmask,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [15:0]          resp_rdata,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [15:0]          wb_addr,
  output logic [LINE_BITS-1:0] wb_data,
  output logic                 fill_req,
  output logic [15:0]          fill_addr,
  input  logic                 fill_done,
  input  logic [LINE_BITS-1:0] fill_data,
  input  logic                 flush_req,
  output logic                 flush_done
);

  localparam int TAG_BITS = 16 - INDEX_BITS - OFFSET_BITS;
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WAY_BITS = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, COMPARE, EVICT, FILL, FLUSH} state_t;

  state_t state, next_state;

  logic [15:0]          lat_addr;
  logic                 lat_write;
  logic [15:0]          lat_wdata;
  logic [1:0]           lat_wmask;
  logic                 first;
  logic [WAY_BITS-1:0]  victim;
  logic [INDEX_BITS-1:0] flush_set;
  logic [WAY_BITS-1:0]  flush_way;

  logic [WAYS-1:0]      valid [SETS];
  logic [WAYS-1:0]      dirty [SETS];
  logic [WAY_BITS-1:0]  age [SETS][WAYS];
  logic [TAG_BITS-1:0]  tag_mem [SETS][WAYS];
  logic [LINE_BITS-1:0] data_mem [SETS][WAYS];

  logic [TAG_BITS-1:0]    lat_tag;
  logic [INDEX_BITS-1:0]  idx;
  logic [OFFSET_BITS-1:0] off;
  logic [OFFSET_BITS-1:0] off_next;
  logic                   off_max;

  assign lat_tag  = lat_addr[15 -: TAG_BITS];
  assign idx      = lat_addr[OFFSET_BITS +: INDEX_BITS];
  assign off      = lat_addr[OFFSET_BITS-1:0];
  assign off_next = off + OFFSET_BITS'(1);
  assign off_max  = (off == '1);

  logic                hit_any;
  logic [WAY_BITS-1:0] hit_way;
  logic                inv_any;
  logic [WAY_BITS-1:0] victim_c;
  logic [7:0]          rd_lo;
  logic [7:0]          rd_hi;

  // Descending scans so the last match taken is the lowest index.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    inv_any  = 1'b0;
    victim_c = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[idx][w] && tag_mem[idx][w] == lat_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid[idx][w]) begin
        inv_any  = 1'b1;
        victim_c = WAY_BITS'(w);
      end
    end
    if (!inv_any) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[idx][w] == WAY_BITS'(WAYS - 1)) victim_c = WAY_BITS'(w);
      end
    end
  end

  assign rd_lo = data_mem[idx][hit_way][{off, 3'b000} +: 8];
  assign rd_hi = off_max ? 8'h00 : data_mem[idx][hit_way][{off_next, 3'b000} +: 8];

  logic f_dirty;
  logic flush_last;
  logic flush_step;

  assign f_dirty    = valid[flush_set][flush_way] && dirty[flush_set][flush_way];
  assign flush_last = (flush_set == '1) && (flush_way == WAY_BITS'(WAYS - 1));
  // A clean entry retires immediately; a dirty one waits for its write-back.
  assign flush_step = !f_dirty || wb_ready;

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_rdata = '0;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    fill_req   = 1'b0;
    fill_addr  = '0;
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          next_state = FLUSH;
        end else begin
          req_ready = 1'b1;
          if (req_valid) next_state = COMPARE;
        end
      end
      COMPARE: begin
        if (hit_any) begin
          resp_valid = 1'b1;
          resp_hit   = first;
          resp_rdata = lat_write ? 16'h0000 : {rd_hi, rd_lo};
          next_state = IDLE;
        end else if (valid[idx][victim_c] && dirty[idx][victim_c]) begin
          next_state = EVICT;
        end else begin
          next_state = FILL;
        end
      end
      EVICT: begin
        wb_valid = 1'b1;
        wb_addr  = {tag_mem[idx][victim], idx, {OFFSET_BITS{1'b0}}};
        wb_data  = data_mem[idx][victim];
        if (wb_ready) next_state = FILL;
      end
      FILL: begin
        fill_req  = 1'b1;
        fill_addr = {lat_tag, idx, {OFFSET_BITS{1'b0}}};
        if (fill_done) next_state = COMPARE;
      end
      FLUSH: begin
        if (f_dirty) begin
          wb_valid = 1'b1;
          wb_addr  = {tag_mem[flush_set][flush_way], flush_set, {OFFSET_BITS{1'b0}}};
          wb_data  = data_mem[flush_set][flush_way];
        end
        if (flush_step && flush_last) begin
          flush_done = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      first     <= 1'b0;
      victim    <= '0;
      flush_set <= '0;
      flush_way <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_BITS'(w);
      end
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (flush_req) begin
            flush_set <= '0;
            flush_way <= '0;
          end else if (req_valid) begin
            lat_addr  <= req_addr;
            lat_write <= req_write;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            first     <= 1'b1;
          end
        end
        COMPARE: begin
          if (hit_any) begin
            // Hit way becomes youngest; only ways younger than it age by one.
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_BITS'(w) == hit_way) age[idx][w] <= '0;
              else if (age[idx][w] < age[idx][hit_way]) age[idx][w] <= age[idx][w] + 1'b1;
            end
            if (lat_write) dirty[idx][hit_way] <= 1'b1;
          end else begin
            first  <= 1'b0;
            victim <= victim_c;
          end
        end
        EVICT: begin
          if (wb_ready) dirty[idx][victim] <= 1'b0;
        end
        FILL: begin
          if (fill_done) begin
            valid[idx][victim] <= 1'b1;
            dirty[idx][victim] <= 1'b0;
          end
        end
        FLUSH: begin
          if (flush_step) begin
            valid[flush_set][flush_way] <= 1'b0;
            dirty[flush_set][flush_way] <= 1'b0;
            if (flush_way == WAY_BITS'(WAYS - 1)) begin
              flush_way <= '0;
              flush_set <= flush_set + 1'b1;
            end else begin
              flush_way <= flush_way + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and line storage carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (state == COMPARE && hit_any && lat_write) begin
      if (lat_wmask[0]) data_mem[idx][hit_way][{off, 3'b000} +: 8] <= lat_wdata[7:0];
      if (lat_wmask[1] && !off_max) data_mem[idx][hit_way][{off_next, 3'b000} +: 8] <= lat_wdata[15:8];
    end
    if (state == FILL && fill_done) begin
      data_mem[idx][victim] <= fill_data;
      tag_mem[idx][victim]  <= lat_tag;
    end
  end

endmodule

// File: tb/tb_cache_assoc_array.sv
// tb/tb_cache_assoc_array.sv - directed self-checking bench for cache_assoc_array
module tb_cache_assoc_array;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [15:0]  req_addr = '0;
  logic         req_write = 1'b0;
  logic [15:0]  req_wdata = '0;
  logic [1:0]   req_wmask = '0;
  logic         resp_valid;
  logic         resp_hit;
  logic [15:0]  resp_rdata;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  logic [15:0]  wb_addr;
  logic [127:0] wb_data;
  logic         fill_req;
  logic [15:0]  fill_addr;
  logic         fill_done = 1'b0;
  logic [127:0] fill_data = '0;
  logic         flush_req = 1'b0;
  logic         flush_done;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_assoc_array dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_done(fill_done), .fill_data(fill_data),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  function automatic logic [127:0] pat(input logic [7:0] base);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[k*8 +: 8] = base + 8'(k);
    return v;
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    wb_ready  = 1'b0;
    fill_done = 1'b0;
    flush_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic issue(input logic [15:0] a, input logic w, input logic [15:0] d, input logic [1:0] m);
    int n;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_wmask = m;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests_run++;
      fails++;
      $display("FAIL issue_timeout addr=%h req_ready=%b required 1", a, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_fill(output logic seen);
    int n;
    n = 0;
    while (!fill_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    seen = fill_req;
  endtask

  task automatic give_fill(input logic [127:0] d);
    fill_data = d;
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_req_ready got %b required 1", req_ready);
    end
    tests_run++;
    if ({resp_valid, resp_hit, wb_valid, fill_req, flush_done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b required 00000", {resp_valid, resp_hit, wb_valid, fill_req, flush_done});
    end
  endtask

  task automatic test_read_miss_hit();
    logic seen;
    issue(16'h1230, 1'b0, 16'h0, 2'b00);
    tests_run++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL miss_no_resp got %b required 0", resp_valid);
    end
    wait_fill(seen);
    tests_run++;
    if (seen !== 1'b1 || fill_addr !== 16'h1230 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL fill_addr_1230 got seen=%b addr=%h wb=%b required 1 1230 0", seen, fill_addr, wb_valid);
    end
    give_fill(pat(8'h00));
    tests_run++;
    if ({resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b0, 16'h0100}) begin
      fails++;
      $display("FAIL miss_resp got %b %b %h required 1 0 0100", resp_valid, resp_hit, resp_rdata);
    end
    @(negedge clk);
    issue(16'h1232, 1'b0, 16'h0, 2'b00);
    tests_run++;
    if ({resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b1, 16'h0302}) begin
      fails++;
      $display("FAIL hit_resp_1232 got %b %b %h required 1 1 0302", resp_valid, resp_hit, resp_rdata);
    end
  endtask

  task automatic test_top_byte();
    logic [15:0] addrs [4] = '{16'h123F, 16'h123F, 16'h123E, 16'h1230};
    logic        wrs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] exps  [4] = '{16'h000F, 16'h0000, 16'h550E, 16'h0100};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(addrs[i], wrs[i], 16'hAB55, 2'b11);
      tests_run++;
      if ({resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b1, exps[i]}) begin
        fails++;
        $display("FAIL top_byte_%0d got %b %b %h required 1 1 %h", i, resp_valid, resp_hit, resp_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_dirty_evict();
    logic seen;
    logic [127:0] exp_line;
    int n;
    do_reset();
    issue(16'h0030, 1'b0, 16'h0, 2'b00);
    wait_fill(seen);
    give_fill(pat(8'h10));
    tests_run++;
    if ({resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b0, 16'h1110}) begin
      fails++;
      $display("FAIL fill_0030 got %b %b %h required 1 0 1110", resp_valid, resp_hit, resp_rdata);
    end
    @(negedge clk);
    issue(16'h0830, 1'b0, 16'h0, 2'b00);
    wait_fill(seen);
    give_fill(pat(8'h20));
    tests_run++;
    if ({resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b0, 16'h2120}) begin
      fails++;
      $display("FAIL fill_0830 got %b %b %h required 1 0 2120", resp_valid, resp_hit, resp_rdata);
    end
    @(negedge clk);
    issue(16'h0030, 1'b1, 16'hBEEF, 2'b11);
    @(negedge clk);
    issue(16'h0830, 1'b0, 16'h0, 2'b00);
    tests_run++;
    if ({resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b1, 16'h2120}) begin
      fails++;
      $display("FAIL touch_0830 got %b %b %h required 1 1 2120", resp_valid, resp_hit, resp_rdata);
    end
    @(negedge clk);
    exp_line = pat(8'h10);
    exp_line[15:0] = 16'hBEEF;
    issue(16'h1030, 1'b0, 16'h0, 2'b00);
    n = 0;
    while (!wb_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (wb_valid !== 1'b1 || wb_addr !== 16'h0030 || wb_data !== exp_line || fill_req !== 1'b0) begin
      fails++;
      $display("FAIL evict_first got v=%b a=%h d=%h f=%b required 1 0030 %h 0", wb_valid, wb_addr, wb_data, fill_req, exp_line);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (wb_valid !== 1'b1 || wb_addr !== 16'h0030 || wb_data !== exp_line || fill_req !== 1'b0) begin
        fails++;
        $display("FAIL evict_stall_%0d got v=%b a=%h f=%b required 1 0030 0", i, wb_valid, wb_addr, fill_req);
      end
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    wait_fill(seen);
    tests_run++;
    if (seen !== 1'b1 || fill_addr !== 16'h1030 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL fill_1030 got seen=%b addr=%h wb=%b required 1 1030 0", seen, fill_addr, wb_valid);
    end
    give_fill(pat(8'h30));
    tests_run++;
    if ({resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b0, 16'h3130}) begin
      fails++;
      $display("FAIL resp_1030 got %b %b %h required 1 0 3130", resp_valid, resp_hit, resp_rdata);
    end
  endtask

  task automatic test_flush();
    logic seen;
    logic done_seen;
    logic got_resp;
    logic [15:0] wba [4];
    int wb_cnt;
    @(negedge clk);
    issue(16'h0830, 1'b1, 16'h1234, 2'b01);
    @(negedge clk);
    issue(16'h1030, 1'b1, 16'h5678, 2'b10);
    @(negedge clk);
    flush_req = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h0830;
    req_write = 1'b0;
    wb_ready  = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_blocks_req got %b required 0", req_ready);
    end
    done_seen = 1'b0;
    got_resp  = 1'b0;
    wb_cnt    = 0;
    for (int n = 0; n < 100 && !done_seen; n++) begin
      @(negedge clk);
      if (resp_valid) got_resp = 1'b1;
      if (wb_valid) begin
        if (wb_cnt < 4) wba[wb_cnt] = wb_addr;
        wb_cnt++;
      end
      if (flush_done) done_seen = 1'b1;
    end
    flush_req = 1'b0;
    req_valid = 1'b0;
    wb_ready  = 1'b0;
    tests_run++;
    if (done_seen !== 1'b1 || got_resp !== 1'b0 || wb_cnt != 2) begin
      fails++;
      $display("FAIL flush_summary got done=%b resp=%b wbs=%0d required 1 0 2", done_seen, got_resp, wb_cnt);
    end else begin
      tests_run++;
      if (wba[0] !== 16'h1030 || wba[1] !== 16'h0830) begin
        fails++;
        $display("FAIL flush_wb_order got %h %h required 1030 0830", wba[0], wba[1]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (flush_done !== 1'b0) begin
      fails++;
      $display("FAIL flush_done_pulse got %b required 0", flush_done);
    end
    issue(16'h0830, 1'b0, 16'h0, 2'b00);
    tests_run++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL flushed_miss got %b required 0", resp_valid);
    end
    wait_fill(seen);
    tests_run++;
    if (seen !== 1'b1 || fill_addr !== 16'h0830) begin
      fails++;
      $display("FAIL flushed_fill got seen=%b addr=%h required 1 0830", seen, fill_addr);
    end
    give_fill(pat(8'h40));
    tests_run++;
    if ({resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b0, 16'h4140}) begin
      fails++;
      $display("FAIL flushed_resp got %b %b %h required 1 0 4140", resp_valid, resp_hit, resp_rdata);
    end
  endtask

  task automatic test_reset_in_fill();
    logic seen;
    @(negedge clk);
    issue(16'h0450, 1'b0, 16'h0, 2'b00);
    wait_fill(seen);
    tests_run++;
    if (seen !== 1'b1 || fill_addr !== 16'h0450) begin
      fails++;
      $display("FAIL pre_reset_fill got seen=%b addr=%h required 1 0450", seen, fill_addr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (fill_req !== 1'b0) begin
      fails++;
      $display("FAIL async_fill_drop got %b required 0", fill_req);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({resp_valid, fill_req, req_ready} !== 3'b001) begin
      fails++;
      $display("FAIL post_reset got %b required 001", {resp_valid, fill_req, req_ready});
    end
    issue(16'h0450, 1'b0, 16'h0, 2'b00);
    tests_run++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_abandon_miss got %b required 0", resp_valid);
    end
    wait_fill(seen);
    give_fill(pat(8'h50));
    tests_run++;
    if ({resp_valid, resp_hit, resp_rdata} !== {1'b1, 1'b0, 16'h5150}) begin
      fails++;
      $display("FAIL reset_refill_resp got %b %b %h required 1 0 5150", resp_valid, resp_hit, resp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_top_byte();
    test_dirty_evict();
    test_flush();
    test_reset_in_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
